cc_nway_tag_compare: RTL and testbench

//  Parametrised N-way successor of the cache controller's single-way tag comparator.
//  - Registers the request (tag/index/offset/pulse) and compares it against all WAYS
//    tag-SRAM entries returned one cycle later.
//  - Reports hit/miss, the hit way and a victim way for misses; flags multi-hit errors.
//  - Victim selection uses per-set tree pseudo-LRU state held inside this block.
//  - Sits between the tag SRAM read port and the cache controller FSM.

---
 rtl/cc_nway_tag_compare_if.sv | 42 ++++
 rtl/cc_nway_tag_compare.sv | 209 ++++++++++++++++++++
 tb/tb_cc_nway_tag_compare.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cc_nway_tag_compare_if.sv
// Request/result bundle between the tag comparator, the tag SRAM read port
// and the cache controller FSM.
interface cc_nway_tag_compare_if #(
   parameter int WAYS  = 4,
   parameter int TAG_W = 18,
   parameter int IDX_W = 8,
   parameter int OFS_W = 6
);
   localparam int WAY_W = $clog2(WAYS);
   localparam int ENT_W = TAG_W + 2;

   logic [TAG_W-1:0]      tag_i;
   logic [IDX_W-1:0]      index_i;
   logic [OFS_W-1:0]      offset_i;
   logic                  hs_pulse_i;
   logic [WAYS*ENT_W-1:0] rdata_tag_i;

   logic [TAG_W-1:0]      tag_delayed_o;
   logic [IDX_W-1:0]      index_delayed_o;
   logic [OFS_W-1:0]      offset_delayed_o;
   logic                  hs_pulse_delayed_o;
   logic                  hit_o;
   logic                  miss_o;
   logic [WAY_W-1:0]      hit_way_o;
   logic [WAY_W-1:0]      victim_way_o;
   logic                  victim_dirty_o;
   logic                  multihit_err_o;

   modport master (
      output tag_i, index_i, offset_i, hs_pulse_i, rdata_tag_i,
      input  tag_delayed_o, index_delayed_o, offset_delayed_o,
      input  hs_pulse_delayed_o, hit_o, miss_o, hit_way_o,
      input  victim_way_o, victim_dirty_o, multihit_err_o
   );

   modport slave (
      input  tag_i, index_i, offset_i, hs_pulse_i, rdata_tag_i,
      output tag_delayed_o, index_delayed_o, offset_delayed_o,
      output hs_pulse_delayed_o, hit_o, miss_o, hit_way_o,
      output victim_way_o, victim_dirty_o, multihit_err_o
   );
endinterface

// File: rtl/cc_nway_tag_compare.sv
// N-way tag comparator with per-set tree pseudo-LRU victim selection.
// Registers the request, compares against SRAM tags one cycle later.
module cc_nway_tag_compare #(
   parameter int WAYS    = 4,
   parameter int TAG_W   = 18,
   parameter int IDX_W   = 8,
   parameter int OFS_W   = 6,
   parameter int OUT_REG = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    fill_i,
   input  logic [IDX_W-1:0]        fill_index_i,
   input  logic [$clog2(WAYS)-1:0] fill_way_i,
   input  logic                    flush_i,
   cc_nway_tag_compare_if.slave    bus
);
   localparam int WAY_W = $clog2(WAYS);
   localparam int ENT_W = TAG_W + 2;
   localparam int NODES = WAYS - 1;
   localparam int SETS  = 1 << IDX_W;

   typedef logic [NODES-1:0] plru_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [IDX_W-1:0] idx;
      logic [OFS_W-1:0] ofs;
      logic             pls;
      logic             hit;
      logic             miss;
      logic [WAY_W-1:0] hway;
      logic [WAY_W-1:0] vway;
      logic             vdirty;
      logic             mhit;
   } res_t;

   // Follow the node bits from the root down to the pointed-at leaf.
   function automatic logic [WAY_W-1:0] plru_walk(input plru_t p);
      int   node;
      logic b;
      plru_walk = '0;
      node = 0;
      for (int l = 0; l < WAY_W; l++) begin
         b = p[node];
         plru_walk[WAY_W-1-l] = b;
         node = 2 * node + (b ? 2 : 1);
      end
   endfunction

   // Make every node on the path of way w point to the other half.
   function automatic plru_t plru_touch(input plru_t p,
                                        input logic [WAY_W-1:0] w);
      int   node;
      logic b;
      plru_touch = p;
      node = 0;
      for (int l = 0; l < WAY_W; l++) begin
         b = w[WAY_W-1-l];
         plru_touch[node] = ~b;
         node = 2 * node + (b ? 2 : 1);
      end
   endfunction

   logic [TAG_W-1:0] tag_q, tag_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [OFS_W-1:0] ofs_q, ofs_d;
   logic             pls_q, pls_d;

   logic [WAYS-1:0]  valid;
   logic [WAYS-1:0]  dirty;
   logic [WAYS-1:0]  match;
   logic             any_match;
   logic             hit_c;
   logic             multihit_c;
   logic [WAY_W-1:0] hit_way_c;
   logic [WAY_W-1:0] victim_c;
   logic             victim_dirty_c;

   plru_t plru_q [SETS];
   plru_t plru_d [SETS];
   plru_t hit_row;
   plru_t fill_base;
   plru_t fill_row;

   res_t res_d;
   res_t res_o;

   // Request capture: next stage values come straight from the bus.
   always_comb begin
      tag_d = bus.tag_i;
      idx_d = bus.index_i;
      ofs_d = bus.offset_i;
      pls_d = bus.hs_pulse_i;
   end

   // Stage C request register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tag_q <= '0;
         idx_q <= '0;
         ofs_q <= '0;
         pls_q <= 1'b0;
      end else begin
         tag_q <= tag_d;
         idx_q <= idx_d;
         ofs_q <= ofs_d;
         pls_q <= pls_d;
      end
   end

   // Split each SRAM entry and compare its tag with the held request.
   always_comb begin
      valid = '0;
      dirty = '0;
      match = '0;
      for (int w = 0; w < WAYS; w++) begin
         valid[w] = bus.rdata_tag_i[w*ENT_W + TAG_W];
         dirty[w] = bus.rdata_tag_i[w*ENT_W + TAG_W + 1];
         match[w] = valid[w] &&
            (bus.rdata_tag_i[w*ENT_W +: TAG_W] == tag_q);
      end
   end

   // Hit encode, multi-hit detect and victim choice.
   always_comb begin
      hit_way_c = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (match[w]) hit_way_c = WAY_W'(w);
      end
      any_match  = |match;
      hit_c      = pls_q & any_match;
      multihit_c = pls_q &
         ((match & (match - WAYS'(1))) != '0);
      if (&valid) begin
         victim_c = plru_walk(plru_q[idx_q]);
      end else begin
         victim_c = '0;
         for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) victim_c = WAY_W'(w);
         end
      end
      victim_dirty_c = dirty[victim_c];
   end

   // Result bundle; status fields read zero outside a stage-C pulse.
   always_comb begin
      res_d        = '0;
      res_d.tag    = tag_q;
      res_d.idx    = idx_q;
      res_d.ofs    = ofs_q;
      res_d.pls    = pls_q;
      res_d.hit    = hit_c;
      res_d.miss   = pls_q & ~any_match;
      res_d.mhit   = multihit_c;
      if (pls_q) begin
         res_d.hway   = hit_way_c;
         res_d.vway   = victim_c;
         res_d.vdirty = victim_dirty_c;
      end
   end

   // PLRU next state: hit first, fill on top, flush overrides all.
   always_comb begin
      hit_row   = plru_touch(plru_q[idx_q], hit_way_c);
      fill_base = (hit_c && (fill_index_i == idx_q)) ?
                  hit_row : plru_q[fill_index_i];
      fill_row  = plru_touch(fill_base, fill_way_i);
      plru_d    = plru_q;
      if (flush_i) begin
         for (int s = 0; s < SETS; s++) plru_d[s] = '0;
      end else begin
         if (hit_c)  plru_d[idx_q]        = hit_row;
         if (fill_i) plru_d[fill_index_i] = fill_row;
      end
   end

   // PLRU state per set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
      end else begin
         plru_q <= plru_d;
      end
   end

   if (OUT_REG != 0) begin : g_oreg
      res_t res_q;
      // Optional output register adding one cycle of latency.
      always_ff @(posedge clk) begin
         if (!rst_n) res_q <= '0;
         else        res_q <= res_d;
      end
      assign res_o = res_q;
   end else begin : g_ocomb
      assign res_o = res_d;
   end

   assign bus.tag_delayed_o      = res_o.tag;
   assign bus.index_delayed_o    = res_o.idx;
   assign bus.offset_delayed_o   = res_o.ofs;
   assign bus.hs_pulse_delayed_o = res_o.pls;
   assign bus.hit_o              = res_o.hit;
   assign bus.miss_o             = res_o.miss;
   assign bus.hit_way_o          = res_o.hway;
   assign bus.victim_way_o       = res_o.vway;
   assign bus.victim_dirty_o     = res_o.vdirty;
   assign bus.multihit_err_o     = res_o.mhit;
endmodule

// File: tb/tb_cc_nway_tag_compare.sv
// Directed bench for cc_nway_tag_compare, one instance per output mode.
// Both instances see identical stimulus.
module tb_cc_nway_tag_compare;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       fill_i;
   logic [7:0] fill_index_i;
   logic [1:0] fill_way_i;
   logic       flush_i;
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   cc_nway_tag_compare_if #(.WAYS(4), .TAG_W(18), .IDX_W(8), .OFS_W(6)) if0 ();
   cc_nway_tag_compare_if #(.WAYS(4), .TAG_W(18), .IDX_W(8), .OFS_W(6)) if1 ();

   cc_nway_tag_compare #(.WAYS(4), .TAG_W(18), .IDX_W(8), .OFS_W(6),
                         .OUT_REG(0)) u0 (
      .clk(clk), .rst_n(rst_n), .fill_i(fill_i),
      .fill_index_i(fill_index_i), .fill_way_i(fill_way_i),
      .flush_i(flush_i), .bus(if0)
   );

   cc_nway_tag_compare #(.WAYS(4), .TAG_W(18), .IDX_W(8), .OFS_W(6),
                         .OUT_REG(1)) u1 (
      .clk(clk), .rst_n(rst_n), .fill_i(fill_i),
      .fill_index_i(fill_index_i), .fill_way_i(fill_way_i),
      .flush_i(flush_i), .bus(if1)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic p, input logic [17:0] t,
                          input logic [7:0] i, input logic [5:0] o);
      if0.hs_pulse_i = p; if1.hs_pulse_i = p;
      if0.tag_i = t;      if1.tag_i = t;
      if0.index_i = i;    if1.index_i = i;
      if0.offset_i = o;   if1.offset_i = o;
   endtask

   task automatic set_rd(input logic [79:0] rd);
      if0.rdata_tag_i = rd;
      if1.rdata_tag_i = rd;
   endtask

   // Pulse one request, leave the bench in its stage-C cycle.
   task automatic req(input logic [17:0] t, input logic [7:0] i,
                      input logic [5:0] o);
      set_req(1'b1, t, i, o);
      step();
      set_req(1'b0, '0, '0, '0);
   endtask

   function automatic logic [19:0] ent(input logic d, input logic v,
                                       input logic [17:0] t);
      return {d, v, t};
   endfunction

   logic [79:0] rd_s2;
   logic [79:0] rd_s3;
   logic [79:0] rd_s4;

   initial begin
      rd_s2 = {ent(0,1,18'h00003), ent(1,1,18'h12345),
               ent(0,1,18'h00002), ent(0,1,18'h00001)};
      rd_s3 = {ent(0,1,18'h04444), ent(1,1,18'h33333),
               ent(0,1,18'h22222), ent(1,1,18'h11111)};
      rd_s4 = {ent(0,1,18'h3FFFF), ent(0,0,18'h3FFFF),
               ent(0,1,18'h3FFFF), ent(0,1,18'h00000)};

      rst_n = 1'b0;
      fill_i = 1'b0; fill_index_i = '0; fill_way_i = '0; flush_i = 1'b0;
      set_req(1'b0, '0, '0, '0);
      set_rd('0);
      step();
      step();
      check("rst_strobe0", 32'(if0.hs_pulse_delayed_o), 0);
      check("rst_miss0", 32'(if0.miss_o), 0);
      check("rst_hit0", 32'(if0.hit_o), 0);
      check("rst_tag0", 32'(if0.tag_delayed_o), 0);
      check("rst_strobe1", 32'(if1.hs_pulse_delayed_o), 0);
      check("rst_miss1", 32'(if1.miss_o), 0);
      rst_n = 1'b1;
      step();

      // all ways invalid: miss, victim way 0
      req(18'h12345, 8'd5, 6'h2A);
      set_rd('0);
      #1;
      check("s1_strobe", 32'(if0.hs_pulse_delayed_o), 1);
      check("s1_miss", 32'(if0.miss_o), 1);
      check("s1_hit", 32'(if0.hit_o), 0);
      check("s1_victim", 32'(if0.victim_way_o), 0);
      check("s1_tag", 32'(if0.tag_delayed_o), 32'h12345);
      check("s1_idx", 32'(if0.index_delayed_o), 5);
      check("s1_ofs", 32'(if0.offset_delayed_o), 32'h2A);
      check("s1_lat1_strobe", 32'(if1.hs_pulse_delayed_o), 0);
      step();
      check("s1_u1_strobe", 32'(if1.hs_pulse_delayed_o), 1);
      check("s1_u1_miss", 32'(if1.miss_o), 1);
      check("s1_strobe_gone", 32'(if0.hs_pulse_delayed_o), 0);
      check("s1_miss_gone", 32'(if0.miss_o), 0);

      // hit in way 2
      req(18'h12345, 8'd5, 6'h01);
      set_rd(rd_s2);
      #1;
      check("s2_hit", 32'(if0.hit_o), 1);
      check("s2_hitway", 32'(if0.hit_way_o), 2);
      check("s2_miss", 32'(if0.miss_o), 0);
      check("s2_mhit", 32'(if0.multihit_err_o), 0);
      step();
      check("s2_plru5", 32'(u0.plru_q[5]), 32'b100);
      check("s2_hitway_gone", 32'(if0.hit_way_o), 0);

      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      check("flush_plru5", 32'(u0.plru_q[5]), 0);

      // all valid miss: PLRU walk and fills
      req(18'h3ABCD, 8'd5, 6'h00);
      set_rd(rd_s3);
      #1;
      check("s3_miss", 32'(if0.miss_o), 1);
      check("s3_victim_a", 32'(if0.victim_way_o), 0);
      check("s3_vdirty_a", 32'(if0.victim_dirty_o), 1);
      step();
      check("s3_nohit_plru", 32'(u0.plru_q[5]), 0);
      fill_i = 1'b1; fill_index_i = 8'd5; fill_way_i = 2'd0;
      step();
      fill_i = 1'b0;
      req(18'h3ABCD, 8'd5, 6'h00);
      #1;
      check("s3_victim_b", 32'(if0.victim_way_o), 2);
      check("s3_vdirty_b", 32'(if0.victim_dirty_o), 1);
      step();
      fill_i = 1'b1; fill_index_i = 8'd5; fill_way_i = 2'd2;
      step();
      fill_i = 1'b0;
      req(18'h3ABCD, 8'd5, 6'h00);
      #1;
      check("s3_victim_c", 32'(if0.victim_way_o), 1);
      check("s3_vdirty_c", 32'(if0.victim_dirty_o), 0);
      step();

      // multi-hit on ways 1 and 3, way 2 invalid
      req(18'h3FFFF, 8'd7, 6'h3F);
      set_rd(rd_s4);
      #1;
      check("s4_hit", 32'(if0.hit_o), 1);
      check("s4_hitway", 32'(if0.hit_way_o), 1);
      check("s4_mhit", 32'(if0.multihit_err_o), 1);
      check("s4_miss", 32'(if0.miss_o), 0);
      check("s4_victim_inv", 32'(if0.victim_way_o), 2);
      step();

      // three back-to-back requests
      set_rd('0);
      set_req(1'b1, 18'h00A01, 8'd1, 6'd1);
      step();
      set_req(1'b1, 18'h00B02, 8'd2, 6'd2);
      #1;
      check("s5_a_strobe", 32'(if0.hs_pulse_delayed_o), 1);
      check("s5_a_tag", 32'(if0.tag_delayed_o), 32'h00A01);
      check("s5_a_idx", 32'(if0.index_delayed_o), 1);
      step();
      set_req(1'b1, 18'h00C03, 8'd3, 6'd3);
      #1;
      check("s5_b_strobe", 32'(if0.hs_pulse_delayed_o), 1);
      check("s5_b_tag", 32'(if0.tag_delayed_o), 32'h00B02);
      check("s5_b_ofs", 32'(if0.offset_delayed_o), 2);
      check("s5_a_u1_tag", 32'(if1.tag_delayed_o), 32'h00A01);
      step();
      set_req(1'b0, '0, '0, '0);
      #1;
      check("s5_c_strobe", 32'(if0.hs_pulse_delayed_o), 1);
      check("s5_c_tag", 32'(if0.tag_delayed_o), 32'h00C03);
      check("s5_c_idx", 32'(if0.index_delayed_o), 3);
      step();
      check("s5_end_strobe", 32'(if0.hs_pulse_delayed_o), 0);

      // reset lands on the second of three pulses
      set_rd(rd_s2);
      set_req(1'b1, 18'h12345, 8'd5, 6'd0);
      step();
      set_req(1'b1, 18'h12345, 8'd5, 6'd1);
      #1;
      check("s5r_a_hit", 32'(if0.hit_o), 1);
      rst_n = 1'b0;
      step();
      set_req(1'b1, 18'h12345, 8'd5, 6'd2);
      check("s5r_strobe_a", 32'(if0.hs_pulse_delayed_o), 0);
      step();
      rst_n = 1'b1;
      set_req(1'b0, '0, '0, '0);
      check("s5r_strobe_b", 32'(if0.hs_pulse_delayed_o), 0);
      step();
      check("s5r_strobe_c", 32'(if0.hs_pulse_delayed_o), 0);
      check("s5r_u1_strobe", 32'(if1.hs_pulse_delayed_o), 0);
      check("s5r_plru5", 32'(u0.plru_q[5]), 0);
      check("s5r_plru7", 32'(u0.plru_q[7]), 0);
      step();
      check("s5r_u1_strobe2", 32'(if1.hs_pulse_delayed_o), 0);

      // output-register mode: scenario 2 at N+2
      req(18'h12345, 8'd5, 6'h11);
      set_rd(rd_s2);
      #1;
      check("s6_n1_strobe", 32'(if1.hs_pulse_delayed_o), 0);
      step();
      check("s6_strobe", 32'(if1.hs_pulse_delayed_o), 1);
      check("s6_hit", 32'(if1.hit_o), 1);
      check("s6_hitway", 32'(if1.hit_way_o), 2);
      check("s6_miss", 32'(if1.miss_o), 0);
      check("s6_tag", 32'(if1.tag_delayed_o), 32'h12345);
      check("s6_ofs", 32'(if1.offset_delayed_o), 32'h11);
      check("s6_plru5", 32'(u1.plru_q[5]), 32'b100);

      // hit way 2 and fill way 1 to set 5 in one cycle
      req(18'h12345, 8'd5, 6'h00);
      fill_i = 1'b1; fill_index_i = 8'd5; fill_way_i = 2'd1;
      step();
      fill_i = 1'b0;
      check("s6_hitfill_plru", 32'(u1.plru_q[5]), 32'b101);
      check("s6_hitfill_way", 32'(if1.hit_way_o), 2);

      req(18'h3ABCD, 8'd5, 6'h00);
      set_rd(rd_s3);
      step();
      check("s6_victim", 32'(if1.victim_way_o), 3);
      check("s6_u1_miss", 32'(if1.miss_o), 1);

      // flush beats a same-cycle hit
      set_rd(rd_s2);
      req(18'h12345, 8'd5, 6'h00);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      check("s6_flush_u1", 32'(u1.plru_q[5]), 0);
      check("s6_flush_u0", 32'(u0.plru_q[5]), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
